// File: rtl/c_requant_drain_pkg.sv
// rtl/c_requant_drain_pkg.sv - shared FSM states and requant constants for the C buffer drain
package c_requant_drain_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_WAIT,
        ST_SCALE,
        ST_ROUND,
        ST_OUT,
        ST_DONE
    } state_t;

    localparam logic [31:0] INT32_MIN  = 32'h8000_0000;
    localparam logic [31:0] INT32_MAX  = 32'h7FFF_FFFF;
    localparam logic [63:0] NUDGE_POS  = 64'h0000_0000_4000_0000;
    localparam logic [63:0] NUDGE_NEG  = 64'hFFFF_FFFF_C000_0001;
    // Added to negative products so the >>31 truncates toward zero instead of -inf
    localparam logic [63:0] TRUNC_BIAS = 64'h0000_0000_7FFF_FFFF;

endpackage

// File: rtl/c_requant_drain_lane.sv
// rtl/c_requant_drain_lane.sv - one int32 lane: bias, left shift, SRDHM, rounding shift, offset, int8 clamp
module c_requant_drain_lane
    import c_requant_drain_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        scale_en,
    input  logic        round_en,
    input  logic        out_en,
    input  logic [31:0] acc,
    input  logic [31:0] bias,
    input  logic [31:0] multiplier,
    input  logic [4:0]  lshift,
    input  logic [4:0]  rshift,
    input  logic [31:0] output_offset,
    input  logic [7:0]  act_min,
    input  logic [7:0]  act_max,
    output logic [7:0]  q
);

    logic [31:0]        x_q;
    logic signed [31:0] y_q;
    logic [31:0]        x_next;
    logic [63:0]        prod, nudged, biased;
    logic [31:0]        y_next;
    logic [31:0]        mask, rem, thr;
    logic signed [31:0] y_sra, z, v, lo, hi;
    logic [7:0]         q_next;

    always_comb begin
        x_next = (acc + bias) << lshift;

        prod   = {{32{x_q[31]}}, x_q} * {{32{multiplier[31]}}, multiplier};
        nudged = prod + (prod[63] ? NUDGE_NEG : NUDGE_POS);
        biased = nudged + (nudged[63] ? TRUNC_BIAS : 64'h0);
        y_next = ((x_q == INT32_MIN) && (multiplier == INT32_MIN)) ? INT32_MAX : 32'(biased >> 31);

        // Round half away from zero on the right shift
        mask  = (32'h1 << rshift) - 32'h1;
        rem   = y_q & mask;
        thr   = (mask >> 1) + {31'b0, y_q[31]};
        y_sra = y_q >>> rshift;
        z     = y_sra + {31'b0, (rem > thr)};
        v     = z + output_offset;

        lo = {{24{act_min[7]}}, act_min};
        hi = {{24{act_max[7]}}, act_max};
        if (v < lo)
            q_next = act_min;
        else if (v > hi)
            q_next = act_max;
        else
            q_next = v[7:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q <= '0;
            y_q <= '0;
            q   <= '0;
        end else begin
            if (scale_en) x_q <= x_next;
            if (round_en) y_q <= y_next;
            if (out_en)   q   <= q_next;
        end
    end

endmodule

// File: rtl/c_requant_drain.sv
// rtl/c_requant_drain.sv - drains C buffer rows through per-lane requant onto a valid/ready stream
module c_requant_drain
    import c_requant_drain_pkg::*;
#(
    parameter int ADDR_BITS = 6,
    parameter int LANES     = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [ADDR_BITS:0]     num_rows,
    input  logic [32*LANES-1:0]    bias,
    input  logic [31:0]            multiplier,
    input  logic [5:0]             shift,
    input  logic [31:0]            output_offset,
    input  logic [7:0]             act_min,
    input  logic [7:0]             act_max,
    output logic                   busy,
    output logic                   done,
    output logic [ADDR_BITS-1:0]   C_index,
    input  logic [32*LANES-1:0]    C_data_out,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [8*LANES-1:0]     out_data,
    output logic [ADDR_BITS-1:0]   out_row
);

    localparam logic [ADDR_BITS:0]   ONE_ROW  = 1;
    localparam logic [ADDR_BITS-1:0] ROW_STEP = 1;

    state_t                state;
    logic [ADDR_BITS:0]    rows_q;
    logic [32*LANES-1:0]   bias_q;
    logic [31:0]           mult_q, offset_q;
    logic [5:0]            shift_q;
    logic [7:0]            amin_q, amax_q;
    logic [4:0]            lshift, rshift;

    assign lshift = shift_q[5] ? 5'd0 : shift_q[4:0];
    assign rshift = shift_q[5] ? (~shift_q[4:0] + 5'd1) : 5'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            out_valid <= 1'b0;
            out_row   <= '0;
            C_index   <= '0;
            rows_q    <= '0;
            bias_q    <= '0;
            mult_q    <= '0;
            offset_q  <= '0;
            shift_q   <= '0;
            amin_q    <= '0;
            amax_q    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        rows_q   <= num_rows;
                        bias_q   <= bias;
                        mult_q   <= multiplier;
                        offset_q <= output_offset;
                        shift_q  <= shift;
                        amin_q   <= act_min;
                        amax_q   <= act_max;
                        busy     <= 1'b1;
                        C_index  <= '0;
                        state    <= (num_rows == '0) ? ST_DONE : ST_READ;
                    end
                end
                ST_READ:  state <= ST_WAIT;
                ST_WAIT:  state <= ST_SCALE;
                ST_SCALE: state <= ST_ROUND;
                ST_ROUND: begin
                    out_valid <= 1'b1;
                    out_row   <= C_index;
                    state     <= ST_OUT;
                end
                ST_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if ({1'b0, C_index} == rows_q - ONE_ROW) begin
                            state <= ST_DONE;
                        end else begin
                            C_index <= C_index + ROW_STEP;
                            state   <= ST_READ;
                        end
                    end
                end
                ST_DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        c_requant_drain_lane u_lane (
            .clk           (clk),
            .rst_n         (rst_n),
            .scale_en      (state == ST_WAIT),
            .round_en      (state == ST_SCALE),
            .out_en        (state == ST_ROUND),
            .acc           (C_data_out[32*LANES-1-32*i -: 32]),
            .bias          (bias_q[32*LANES-1-32*i -: 32]),
            .multiplier    (mult_q),
            .lshift        (lshift),
            .rshift        (rshift),
            .output_offset (offset_q),
            .act_min       (amin_q),
            .act_max       (amax_q),
            .q             (out_data[8*LANES-1-8*i -: 8])
        );
    end

endmodule

// File: tb/tb_c_requant_drain.sv
// tb/tb_c_requant_drain.sv - directed and randomized scoreboard bench for c_requant_drain
module tb_c_requant_drain;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [6:0]   num_rows;
    logic [127:0] bias;
    logic [31:0]  multiplier;
    logic [5:0]   shift;
    logic [31:0]  output_offset;
    logic [7:0]   act_min, act_max;
    logic         busy, done, out_valid, out_ready;
    logic [5:0]   C_index, out_row;
    logic [127:0] C_data_out;
    logic [31:0]  out_data;

    logic [127:0] mem [0:63];

    typedef struct {
        logic [5:0]  row;
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];

    int n_checks = 0;
    int n_fail   = 0;
    int n_xfer   = 0;
    int n_done   = 0;

    c_requant_drain dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_rows(num_rows), .bias(bias),
        .multiplier(multiplier), .shift(shift), .output_offset(output_offset),
        .act_min(act_min), .act_max(act_max), .busy(busy), .done(done),
        .C_index(C_index), .C_data_out(C_data_out), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_row(out_row)
    );

    always #5 clk = ~clk;

    always @(posedge clk) C_data_out <= mem[C_index];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (done) n_done++;
            if (out_valid && out_ready) begin
                exp_t e;
                n_xfer++;
                check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("out_row", 64'(out_row), 64'(e.row));
                    check("out_data", 64'(out_data), 64'(e.data));
                end
            end
        end
    end

    function automatic logic [7:0] model(input int acc, input int b, input int m, input int sh,
                                         input int off, input int amin, input int amax);
        int x, y, v, r;
        longint p, n, yl, z, half;
        x = acc + b;
        if (sh > 0) x = x << sh;
        if (x == 32'h8000_0000 && m == 32'h8000_0000) begin
            y = 32'h7FFF_FFFF;
        end else begin
            p = longint'(x) * longint'(m);
            n = (p >= 0) ? 64'sd1073741824 : (64'sd1 - 64'sd1073741824);
            y = int'((p + n) / 64'sd2147483648);
        end
        r  = (sh < 0) ? -sh : 0;
        yl = y;
        if (r == 0) begin
            z = yl;
        end else begin
            half = longint'(1) << (r - 1);
            z = (yl >= 0) ? ((yl + half) >>> r) : -((-yl + half) >>> r);
        end
        v = int'(z) + off;
        if (v < amin) v = amin;
        else if (v > amax) v = amax;
        return v[7:0];
    endfunction

    task automatic set_cfg(input int b, input logic [31:0] m, input int sh, input int off,
                           input int amin, input int amax);
        bias          = {b, b, b, b};
        multiplier    = m;
        shift         = 6'(sh);
        output_offset = off;
        act_min       = 8'(amin);
        act_max       = 8'(amax);
    endtask

    task automatic load_row(input int r, input int a0, input int a1, input int a2, input int a3);
        mem[r] = {a0, a1, a2, a3};
    endtask

    task automatic push(input int r, input logic [31:0] d);
        exp_t e;
        e.row  = 6'(r);
        e.data = d;
        sb.push_back(e);
    endtask

    task automatic start_drain(input int n);
        num_rows = 7'(n);
        start    = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        check(tag, 64'(got), 64'd1);
        @(posedge clk); #1;
    endtask

    task automatic wait_valid(input string tag);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (out_valid) begin
                got = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        check(tag, 64'(got), 64'd1);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_data"}, 64'(out_data), 64'd0);
        check({tag, "_row"}, 64'(out_row), 64'd0);
        check({tag, "_cidx"}, 64'(C_index), 64'd0);
    endtask

    initial begin
        int x0, d0;
        int rb, rm, rsh, roff;
        int acc [4];
        logic [31:0] e;

        for (int i = 0; i < 64; i++) mem[i] = '0;
        rst_n = 1'b0; start = 1'b0; out_ready = 1'b1; num_rows = '0;
        set_cfg(0, 32'h4000_0000, 1, 0, -128, 127);
        repeat (3) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // identity scaling and first-row latency
        load_row(0, 100, 100, 100, 100);
        push(0, 32'h6464_6464);
        start_drain(1);
        check("t1_busy", 64'(busy), 64'd1);
        repeat (3) @(posedge clk);
        #1;
        check("t1_valid_early", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        check("t1_valid_edge4", 64'(out_valid), 64'd1);
        wait_done("t1_done");
        check("t1_busy_after", 64'(busy), 64'd0);

        set_cfg(0, 32'h4000_0000, -1, 0, -128, 127);
        load_row(0, 3, -3, 3, -3);
        push(0, 32'h01FF_01FF);
        start_drain(1);
        wait_done("t2_done");

        set_cfg(0, 32'h8000_0000, 0, 0, -128, 127);
        load_row(0, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000);
        push(0, 32'h7F7F_7F7F);
        start_drain(1);
        wait_done("t3_done");

        set_cfg(0, 32'h4000_0000, 1, -128, -128, 127);
        load_row(0, -500, 0, 200, 300);
        push(0, 32'h8080_487F);
        start_drain(1);
        wait_done("t4_done");

        // backpressure on row 1
        set_cfg(0, 32'h4000_0000, 1, 0, -128, 127);
        for (int r = 0; r < 3; r++) begin
            load_row(r, r * 10 + 1, -(r + 1), 127, -128);
            push(r, {8'(r * 10 + 1), 8'(-(r + 1)), 8'h7F, 8'h80});
        end
        x0 = n_xfer; d0 = n_done;
        out_ready = 1'b0;
        start_drain(3);
        wait_valid("t5_valid_row0");
        check("t5_row0", 64'(out_row), 64'd0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        wait_valid("t5_valid_row1");
        for (int i = 0; i < 10; i++) begin
            check("t5_hold_valid", 64'(out_valid), 64'd1);
            check("t5_hold_row", 64'(out_row), 64'd1);
            check("t5_hold_cidx", 64'(C_index), 64'd1);
            check("t5_hold_data", 64'(out_data), 64'h0BFE_7F80);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        wait_done("t5_done");
        repeat (3) @(posedge clk);
        #1;
        check("t5_xfers", 64'(n_xfer - x0), 64'd3);
        check("t5_done_pulses", 64'(n_done - d0), 64'd1);

        // zero-row drain
        x0 = n_xfer;
        start_drain(0);
        check("t6_busy", 64'(busy), 64'd1);
        check("t6_done_early", 64'(done), 64'd0);
        @(posedge clk); #1;
        check("t6_done", 64'(done), 64'd1);
        check("t6_busy_off", 64'(busy), 64'd0);
        check("t6_valid", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        check("t6_done_pulse", 64'(done), 64'd0);
        check("t6_xfers", 64'(n_xfer - x0), 64'd0);

        // reset in the middle of a drain
        for (int r = 0; r < 4; r++) begin
            load_row(r, 5, 6, 7, 8);
            push(r, 32'h0506_0708);
        end
        start_drain(4);
        repeat (7) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_zero_outputs("midrst");
        sb.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // randomized drain after reset
        rb   = int'($urandom_range(0, 2000)) - 1000;
        rm   = int'($urandom);
        rsh  = int'($urandom_range(0, 12)) - 8;
        roff = int'($urandom_range(0, 40)) - 20;
        set_cfg(rb, rm, rsh, roff, -100, 100);
        for (int r = 0; r < 6; r++) begin
            for (int l = 0; l < 4; l++) acc[l] = int'($urandom) >>> $urandom_range(0, 24);
            load_row(r, acc[0], acc[1], acc[2], acc[3]);
            for (int l = 0; l < 4; l++) e[31 - 8 * l -: 8] = model(acc[l], rb, rm, rsh, roff, -100, 100);
            push(r, e);
        end
        x0 = n_xfer;
        start_drain(6);
        wait_done("t7_done");
        check("t7_xfers", 64'(n_xfer - x0), 64'd6);
        check("t7_sb_empty", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
